// File: rtl/postfix_eval.sv
// postfix_eval: streaming postfix (RPN) expression evaluator.
// Tokens arrive one per cycle. A token is either an operand, which is pushed,
// or an operator, which pops two entries and pushes one. The first idle cycle
// after a burst of tokens ends the expression. The result is then presented
// for OUT_HOLD cycles, and the evaluator returns to idle.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      synchronous active-high reset
//   IN_VALID   token valid this cycle
//   OP_MODE    0 = IN is an operand, 1 = IN is an operator code
//   IN         4-bit operand (zero-extended) or operator code
//   OUT_VALID  result valid (high for OUT_HOLD cycles)
//   OUT        result, forced to 0 on error
//   ERR        expression error, qualified by OUT_VALID
//   STACK_CNT  current stack occupancy
module postfix_eval #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int SAT      = 0,
    parameter int OUT_HOLD = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       IN_VALID,
    input  logic                       OP_MODE,
    input  logic [3:0]                 IN,
    output logic                       OUT_VALID,
    output logic [DATA_W-1:0]          OUT,
    output logic                       ERR,
    output logic [$clog2(DEPTH+1)-1:0] STACK_CNT
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int HOLD_W = (OUT_HOLD > 1) ? $clog2(OUT_HOLD) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OUT_HOLD - 1);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                latch_q, latch_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   stack_q [DEPTH];

    logic                op_ok_s;
    logic [IDX_W-1:0]    idx_a_s, idx_b_s;
    logic [DATA_W-1:0]   a_s, b_s, res_s;
    logic                illegal_s;
    logic [DATA_W:0]     sum_s;
    logic [2*DATA_W-1:0] prod_s;
    logic                tok_s;
    logic                wr_en_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [DATA_W-1:0]   wr_data_s;

    // Operator datapath: fetch the two top entries and compute the result at full precision.
    always_comb begin
        op_ok_s   = (cnt_q >= CNT_W'(2));
        // The indices are guarded so the stack is never read out of range when there are too few entries.
        idx_a_s   = op_ok_s ? IDX_W'(cnt_q - CNT_W'(2)) : {IDX_W{1'b0}};
        idx_b_s   = op_ok_s ? IDX_W'(cnt_q - CNT_W'(1)) : {IDX_W{1'b0}};
        a_s       = stack_q[idx_a_s];
        b_s       = stack_q[idx_b_s];
        sum_s     = {1'b0, a_s} + {1'b0, b_s};
        prod_s    = {{DATA_W{1'b0}}, a_s} * {{DATA_W{1'b0}}, b_s};
        illegal_s = 1'b0;
        res_s     = {DATA_W{1'b0}};
        case (IN)
            OP_ADD: begin
                if ((SAT != 0) && sum_s[DATA_W]) res_s = {DATA_W{1'b1}};
                else                             res_s = sum_s[DATA_W-1:0];
            end
            OP_SUB: begin
                if ((SAT != 0) && (a_s < b_s)) res_s = {DATA_W{1'b0}};
                else                           res_s = a_s - b_s;
            end
            OP_MUL: begin
                if ((SAT != 0) && (|prod_s[2*DATA_W-1:DATA_W])) res_s = {DATA_W{1'b1}};
                else                                            res_s = prod_s[DATA_W-1:0];
            end
            OP_AND:  res_s = a_s & b_s;
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state logic: sequencing of the FSM, result capture, and token execution.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        latch_d     = latch_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        err_d       = err_q;
        wr_en_s     = 1'b0;
        wr_idx_s    = {IDX_W{1'b0}};
        wr_data_s   = {DATA_W{1'b0}};

        case (state_q)
            S_IDLE: begin
                if (IN_VALID) state_d = S_RUN;
                else          state_d = S_IDLE;
            end
            S_RUN: begin
                if (!IN_VALID) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                    hold_d      = HOLD_LOAD;
                    if (latch_q || (cnt_q != CNT_W'(1))) begin
                        err_d = 1'b1;
                        out_d = {DATA_W{1'b0}};
                    end else begin
                        err_d = 1'b0;
                        out_d = stack_q[0];
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HOLD: begin
                if (hold_q == {HOLD_W{1'b0}}) begin
                    // OUT keeps its last value; only valid, error and the stack are cleared.
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    err_d       = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    latch_d     = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Tokens act only outside HOLD. Once an error has latched, the stack is frozen.
        tok_s = IN_VALID && (state_q != S_HOLD) && !latch_q;
        if (tok_s) begin
            if (!OP_MODE) begin
                if (cnt_q == DEPTH_C) begin
                    latch_d = 1'b1;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = IDX_W'(cnt_q);
                    wr_data_s = {{(DATA_W-4){1'b0}}, IN};
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end else begin
                if (!op_ok_s || illegal_s) begin
                    latch_d = 1'b1;
                end else begin
                    wr_en_s   = 1'b1;
                    wr_idx_s  = idx_a_s;
                    wr_data_s = res_s;
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // State, result and stack registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            latch_q     <= 1'b0;
            hold_q      <= {HOLD_W{1'b0}};
            out_valid_q <= 1'b0;
            out_q       <= {DATA_W{1'b0}};
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            latch_q     <= latch_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            err_q       <= err_d;
            if (wr_en_s) stack_q[wr_idx_s] <= wr_data_s;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign OUT       = out_q;
    assign ERR       = err_q;
    assign STACK_CNT = cnt_q;

endmodule

// File: tb/tb_postfix_eval.sv
// tb_postfix_eval: directed, table-driven bench for postfix_eval.
// Six instances share one token stream:
//   A 16-bit wrap, B 16-bit saturating, C 8-bit wrap, D 8-bit saturating,
//   E 16-bit wrap with DEPTH=4, F 16-bit wrap with OUT_HOLD=3.
module tb_postfix_eval;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET, IN_VALID, OP_MODE;
    logic [3:0] IN;

    logic        va, vb, vc, vd, ve, vf;
    logic        ea, eb, ec, ed, ee, ef;
    logic [15:0] oa, ob, oe, of_;
    logic [7:0]  oc, od;
    logic [4:0]  ca, cb, cc, cd, cf;
    logic [2:0]  ce;

    postfix_eval #(.DATA_W(16), .DEPTH(16), .SAT(0), .OUT_HOLD(1)) u_a (.CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .OP_MODE(OP_MODE), .IN(IN), .OUT_VALID(va), .OUT(oa), .ERR(ea), .STACK_CNT(ca));
    postfix_eval #(.DATA_W(16), .DEPTH(16), .SAT(1), .OUT_HOLD(1)) u_b (.CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .OP_MODE(OP_MODE), .IN(IN), .OUT_VALID(vb), .OUT(ob), .ERR(eb), .STACK_CNT(cb));
    postfix_eval #(.DATA_W(8),  .DEPTH(16), .SAT(0), .OUT_HOLD(1)) u_c (.CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .OP_MODE(OP_MODE), .IN(IN), .OUT_VALID(vc), .OUT(oc), .ERR(ec), .STACK_CNT(cc));
    postfix_eval #(.DATA_W(8),  .DEPTH(16), .SAT(1), .OUT_HOLD(1)) u_d (.CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .OP_MODE(OP_MODE), .IN(IN), .OUT_VALID(vd), .OUT(od), .ERR(ed), .STACK_CNT(cd));
    postfix_eval #(.DATA_W(16), .DEPTH(4),  .SAT(0), .OUT_HOLD(1)) u_e (.CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .OP_MODE(OP_MODE), .IN(IN), .OUT_VALID(ve), .OUT(oe), .ERR(ee), .STACK_CNT(ce));
    postfix_eval #(.DATA_W(16), .DEPTH(16), .SAT(0), .OUT_HOLD(3)) u_f (.CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .OP_MODE(OP_MODE), .IN(IN), .OUT_VALID(vf), .OUT(of_), .ERR(ef), .STACK_CNT(cf));

    localparam logic [4:0] ADD = 5'b1_0001;
    localparam logic [4:0] SUB = 5'b1_0010;
    localparam logic [4:0] MUL = 5'b1_0100;
    localparam logic [4:0] ANDO = 5'b1_1000;
    localparam logic [4:0] BAD = 5'b1_0011;

    // Tokens are packed 5 bits each, first token in the most significant used slot.
    typedef struct {
        int          n;
        logic [49:0] toks;
        int          ew;
        int          es;
        int          e8w;
        int          e8s;
        bit          err;
    } vec_t;

    vec_t vt [11];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [4:0] o(input int v);
        return {1'b0, v[3:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive n tokens, then one idle beat; return at the first sample point with the result visible.
    task automatic send_toks(input int n, input logic [49:0] toks);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            {OP_MODE, IN} = toks[(n-1-i)*5 +: 5];
        end
        @(negedge CLK);
        chk("pre_valid", 32'(va), 32'd0);
        IN_VALID = 1'b0;
        OP_MODE  = 1'b0;
        IN       = 4'd0;
        @(negedge CLK);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   xw, xs, x8w, x8s;
        v   = vt[k];
        xw  = v.err ? 0 : v.ew;
        xs  = v.err ? 0 : v.es;
        x8w = v.err ? 0 : v.e8w;
        x8s = v.err ? 0 : v.e8s;
        send_toks(v.n, v.toks);
        chk($sformatf("v%0d_A_valid", k), 32'(va), 32'd1);
        chk($sformatf("v%0d_A_out", k),   32'(oa), 32'(xw));
        chk($sformatf("v%0d_A_err", k),   32'(ea), 32'(v.err));
        chk($sformatf("v%0d_B_valid", k), 32'(vb), 32'd1);
        chk($sformatf("v%0d_B_out", k),   32'(ob), 32'(xs));
        chk($sformatf("v%0d_B_err", k),   32'(eb), 32'(v.err));
        chk($sformatf("v%0d_C_valid", k), 32'(vc), 32'd1);
        chk($sformatf("v%0d_C_out", k),   32'(oc), 32'(x8w));
        chk($sformatf("v%0d_C_err", k),   32'(ec), 32'(v.err));
        chk($sformatf("v%0d_D_valid", k), 32'(vd), 32'd1);
        chk($sformatf("v%0d_D_out", k),   32'(od), 32'(x8s));
        chk($sformatf("v%0d_D_err", k),   32'(ed), 32'(v.err));
        chk($sformatf("v%0d_E_valid", k), 32'(ve), 32'd1);
        chk($sformatf("v%0d_E_out", k),   32'(oe), 32'(xw));
        chk($sformatf("v%0d_E_err", k),   32'(ee), 32'(v.err));
        chk($sformatf("v%0d_F_valid", k), 32'(vf), 32'd1);
        chk($sformatf("v%0d_F_out", k),   32'(of_), 32'(xw));
        chk($sformatf("v%0d_F_err", k),   32'(ef), 32'(v.err));
        @(negedge CLK);
        chk($sformatf("v%0d_A_drop", k),  32'(va), 32'd0);
        chk($sformatf("v%0d_A_errclr", k), 32'(ea), 32'd0);
        chk($sformatf("v%0d_A_cnt0", k),  32'(ca), 32'd0);
        chk($sformatf("v%0d_F_still", k), 32'(vf), 32'd1);
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int          exp_cnt [5];
        logic [49:0] tk;

        vt[0]  = '{5, {o(3), o(4), ADD, o(2), MUL},                         14,    14,    14,  14,  1'b0};
        vt[1]  = '{3, {o(2), o(5), SUB},                                    65533, 0,     253, 0,   1'b0};
        vt[2]  = '{5, {o(15), o(15), MUL, o(15), MUL},                      3375,  3375,  47,  255, 1'b0};
        vt[3]  = '{3, {o(12), o(10), ANDO},                                 8,     8,     8,   8,   1'b0};
        vt[4]  = '{7, {o(15), o(15), MUL, o(15), o(15), MUL, ADD},          450,   450,   194, 255, 1'b0};
        vt[5]  = '{9, {o(15), o(15), MUL, o(15), o(15), MUL, MUL, o(15), MUL}, 38479, 65535, 79, 255, 1'b0};
        vt[6]  = '{2, {o(3), ADD},                                          0,     0,     0,   0,   1'b1};
        vt[7]  = '{3, {o(1), o(2), BAD},                                    0,     0,     0,   0,   1'b1};
        vt[8]  = '{2, {o(1), o(2)},                                         0,     0,     0,   0,   1'b1};
        vt[9]  = '{3, {o(7), o(1), ADD},                                    8,     8,     8,   8,   1'b0};
        vt[10] = '{1, {o(9)},                                               9,     9,     9,   9,   1'b0};

        RESET = 1'b1; IN_VALID = 1'b0; OP_MODE = 1'b0; IN = 4'd0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_A_valid", 32'(va), 32'd0);
        chk("rst_A_out",   32'(oa), 32'd0);
        chk("rst_A_err",   32'(ea), 32'd0);
        chk("rst_A_cnt",   32'(ca), 32'd0);
        chk("rst_F_valid", 32'(vf), 32'd0);
        chk("rst_E_cnt",   32'(ce), 32'd0);

        for (int k = 0; k < 11; k++) run_vec(k);

        // Occupancy trace over 3,4,+,2,*.
        exp_cnt = '{1, 2, 1, 2, 1};
        tk = {o(3), o(4), ADD, o(2), MUL};
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1;
            {OP_MODE, IN} = tk[(4-i)*5 +: 5];
            @(posedge CLK); #1;
            chk($sformatf("trace_cnt%0d", i), 32'(ca), 32'(exp_cnt[i]));
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        chk("trace_hold_cnt", 32'(ca), 32'd1);
        chk("trace_valid",    32'(va), 32'd1);
        chk("trace_out",      32'(oa), 32'd14);
        @(posedge CLK); #1;
        chk("trace_idle_cnt", 32'(ca), 32'd0);
        chk("trace_drop",     32'(va), 32'd0);
        repeat (4) @(negedge CLK);

        // Overflow on the 4-deep instance: five pushes.
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            IN_VALID = 1'b1; OP_MODE = 1'b0; IN = 4'd1;
        end
        @(negedge CLK);
        chk("ovf_E_cnt", 32'(ce), 32'd4);
        chk("ovf_A_cnt", 32'(ca), 32'd5);
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("ovf_E_valid", 32'(ve), 32'd1);
        chk("ovf_E_err",   32'(ee), 32'd1);
        chk("ovf_E_out",   32'(oe), 32'd0);
        chk("ovf_E_cnt2",  32'(ce), 32'd4);
        chk("ovf_A_err",   32'(ea), 32'd1);
        repeat (4) @(negedge CLK);

        // Three-cycle hold with an ignored beat, then a fresh expression.
        send_toks(3, {o(7), o(1), ADD});
        chk("h3_valid1", 32'(vf), 32'd1);
        chk("h3_out1",   32'(of_), 32'd8);
        IN_VALID = 1'b1; OP_MODE = 1'b0; IN = 4'd5;
        @(negedge CLK);
        IN_VALID = 1'b0; IN = 4'd0;
        chk("h3_valid2", 32'(vf), 32'd1);
        chk("h3_out2",   32'(of_), 32'd8);
        chk("h3_cnt2",   32'(cf), 32'd1);
        chk("h3_A_cnt",  32'(ca), 32'd0);
        chk("h3_A_idle", 32'(va), 32'd0);
        @(negedge CLK);
        chk("h3_valid3", 32'(vf), 32'd1);
        chk("h3_out3",   32'(of_), 32'd8);
        @(negedge CLK);
        chk("h3_drop",    32'(vf), 32'd0);
        chk("h3_keepout", 32'(of_), 32'd8);
        chk("h3_errclr",  32'(ef), 32'd0);
        chk("h3_cnt0",    32'(cf), 32'd0);
        repeat (2) @(negedge CLK);
        send_toks(1, {o(9)});
        chk("h3_next_valid", 32'(vf), 32'd1);
        chk("h3_next_out",   32'(of_), 32'd9);
        repeat (5) @(negedge CLK);

        // Reset in the middle of an expression.
        @(negedge CLK); IN_VALID = 1'b1; OP_MODE = 1'b0; IN = 4'd3;
        @(negedge CLK); IN = 4'd4;
        @(negedge CLK); IN_VALID = 1'b0; RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        chk("rmid_valid", 32'(va), 32'd0);
        chk("rmid_cnt",   32'(ca), 32'd0);
        chk("rmid_F_cnt", 32'(cf), 32'd0);
        @(negedge CLK);
        chk("rmid_valid2", 32'(va), 32'd0);
        send_toks(3, {o(6), o(2), SUB});
        chk("rmid_next_valid", 32'(va), 32'd1);
        chk("rmid_next_out",   32'(oa), 32'd4);
        chk("rmid_next_err",   32'(ea), 32'd0);
        repeat (5) @(negedge CLK);

        // Reset while holding a result.
        send_toks(3, {o(7), o(1), ADD});
        chk("rhold_valid", 32'(vf), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("rhold_drop", 32'(vf), 32'd0);
        chk("rhold_out",  32'(of_), 32'd0);
        chk("rhold_cnt",  32'(cf), 32'd0);
        @(negedge CLK);
        chk("rhold_idle", 32'(vf), 32'd0);
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/postfix_eval.md
Name: postfix_eval

Overview:
- Parametrised streaming postfix (RPN) expression evaluator: accepts one token per cycle (operand or operator), evaluates on an internal stack, and presents the result plus an error flag when the token stream ends.
- Successor to the fixed 16-bit evaluator: adds configurable data width and stack depth, optional saturating arithmetic, programmable result-hold time, and explicit underflow/overflow/illegal-opcode detection.

Parameters:
- DATA_W, 16, stack entry and result width (≥4).
- DEPTH, 16, stack entries (≥2).
- SAT, 0, 0 = wrap-around arithmetic (mod 2^DATA_W); 1 = unsigned saturating arithmetic.
- OUT_HOLD, 1, cycles OUT_VALID stays high per result (≥1).

Ports:
- CLK  input  1  clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  token valid this cycle.
- OP_MODE  input  1  0 = IN is operand, 1 = IN is operator code.
- IN  input  4  operand value (zero-extended to DATA_W) or operator code.
- OUT_VALID  output  1  result valid.
- OUT  output  DATA_W  result; 0 when ERR=1.
- ERR  output  1  expression error; qualified by OUT_VALID.
- STACK_CNT  output  clog2(DEPTH+1)  current stack occupancy.

Behaviour:
- Reset (RESET high at rising CLK edge): state=IDLE, stack occupancy 0, error latch 0, OUT_VALID=0, OUT=0, ERR=0, STACK_CNT=0. Reset overrides everything, including mid-expression and mid-hold; the partial expression is discarded and no result is emitted.
- States: IDLE, RUN, HOLD.
- IDLE: OUT_VALID=0. An IN_VALID beat is processed as the first token and state→RUN. IN_VALID low: stay.
- RUN: each IN_VALID beat is processed (one token per cycle, no backpressure). First edge with IN_VALID=0 → HOLD. On that edge, OUT/ERR are loaded and OUT_VALID is set (registered), so the result is visible in the cycle after the last beat's cycle +1: last beat sampled at edge k, IN_VALID low at edge k+1, OUT_VALID high from after edge k+1.
- Operand (OP_MODE=0): push {0,IN}. If occupancy==DEPTH: overflow, set error latch, stack unchanged.
- Operator (OP_MODE=1): pop b (top), pop a, push result. Codes: 4'b0001 a+b, 4'b0010 a−b, 4'b0100 a*b, 4'b1000 a&b (new). Any other code: illegal opcode error. Occupancy<2: underflow error, stack unchanged.
- Arithmetic: computed at full precision. SAT=0 keeps the low DATA_W bits. SAT=1: add/mul clamp to 2^DATA_W−1; sub clamps to 0 when a<b. AND is unaffected by SAT.
- Error latch is sticky for the expression: once set, further tokens are ignored (stack frozen) until HOLD completes.
- Result on entering HOLD:
  - ERR=1, OUT=0 if the latch is set or final occupancy≠1.
  - Otherwise ERR=0, OUT=top of stack.
- HOLD: OUT_VALID, OUT and ERR are stable for exactly OUT_HOLD cycles. IN_VALID beats during HOLD are ignored (not buffered). On the last hold cycle's edge: OUT_VALID=0, occupancy=0, latch cleared, state→IDLE. OUT keeps its last value. ERR is cleared to 0.
- STACK_CNT reflects occupancy after each edge. It remains at the final value through HOLD and is 0 in IDLE after HOLD.

Test Plan:
- DATA_W=16, SAT=0: tokens 3,4,+(0001),2,*(0100), then IN_VALID low → OUT_VALID high 1 cycle, two edges after the last token; OUT=14, ERR=0; STACK_CNT 1→2→1→2→1 then 0.
- Sub wrap vs saturate: 2,5,−(0010). SAT=0 → OUT=16'hFFFD, ERR=0. SAT=1 → OUT=0, ERR=0.
- DATA_W=8: 15,15,*,15,* → SAT=0 OUT=8'd47 (3375 mod 256); SAT=1 OUT=8'd255. Also 12,10,AND(1000) → OUT=8.
- Errors:
  - 3,+ (underflow) → ERR=1, OUT=0.
  - DEPTH=4 with 5 operand pushes → ERR=1 and STACK_CNT stays 4.
  - 1,2,opcode 0011 → ERR=1.
  - 1,2 with no operator (final occupancy 2) → ERR=1.
- OUT_HOLD=3: expression 7,1,+ → OUT_VALID high exactly 3 cycles with OUT=8; a beat injected during hold is ignored; the next expression 9 evaluates to OUT=9.
- Reset mid-operation: RESET high for one edge after tokens 3,4 → OUT_VALID stays 0, STACK_CNT=0. Then 6,2,− → OUT=4. RESET during HOLD drops OUT_VALID at that edge.
